// File: rtl/gc_dispatcher_pkg.sv
// Shared definitions for the gc_dispatcher slice.
//   - Default sizing for the dispatcher: core count, counter, stride and
//     iteration-count widths.
//   - Dispatcher state encoding used by the top-level FSM.
package gc_dispatcher_pkg;

  localparam int N_CORE_DEF    = 6;
  localparam int GC_WIDTH_DEF  = 32;
  localparam int GD_WIDTH_DEF  = 16;
  localparam int CNT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    DISP_IDLE  = 2'd0,
    DISP_RUN   = 2'd1,
    DISP_DRAIN = 2'd2
  } disp_state_e;

endpackage : gc_dispatcher_pkg

// File: rtl/gc_prefix_count.sv
// Exclusive prefix popcount over an N-bit vector.
//   bits   : input vector
//   prefix : prefix[i] = number of set bits in bits[i-1:0] (prefix[0] = 0)
//   total  : number of set bits in the whole vector
// Purely combinational. Each running sum lives in its own generate scope
// so the ripple chain is a set of independent nets rather than one vector
// that feeds back into itself.
module gc_prefix_count #(
  parameter int N  = 6,
  parameter int CW = $clog2(N) + 1
) (
  input  logic [N-1:0]         bits,
  output logic [N-1:0][CW-1:0] prefix,
  output logic [CW-1:0]        total
);

  genvar gi;
  generate
    for (gi = 0; gi <= N; gi++) begin : g_acc
      logic [CW-1:0] cnt;
      if (gi == 0) begin : g_first
        assign cnt = '0;
      end else begin : g_next
        assign cnt = g_acc[gi-1].cnt + CW'(bits[gi-1]);
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_out
      assign prefix[gi] = g_acc[gi].cnt;
    end
  endgenerate

  assign total = g_acc[N].cnt;

endmodule : gc_prefix_count

// File: rtl/gc_dispatcher.sv
// Central work-index dispatcher for the parallel region.
// A parent fork loads a start value (gc), a signed stride (gd) and an
// iteration count. While running, every cycle the requesting cores are
// granted consecutive indices in core-index order until the count runs out;
// the dispatcher then drains until all child cores report ending and pulses
// done.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   fork_valid/ready  : fork handshake (ready only while idle)
//   fork_gc/gd/count  : start value, signed stride, number of indices
//   req_valid[i]      : core i wants one index this cycle
//   grant[i]          : core i receives gc_assign[i] this cycle (combinational)
//   gc_assign[i]      : index for core i, valid only with grant[i]
//   gd_sign           : sign bit of the current stride
//   ending[i]         : child core i is idle/ending (bit 0 unused)
//   remaining         : indices not yet handed out
//   running           : dispatcher is in RUN
//   done              : one-cycle pulse when DRAIN completes
module gc_dispatcher
  import gc_dispatcher_pkg::*;
#(
  parameter int N_CORE    = N_CORE_DEF,
  parameter int GC_WIDTH  = GC_WIDTH_DEF,
  parameter int GD_WIDTH  = GD_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fork_valid,
  output logic                             fork_ready,
  input  logic [GC_WIDTH-1:0]              fork_gc,
  input  logic [GD_WIDTH-1:0]              fork_gd,
  input  logic [CNT_WIDTH-1:0]             fork_count,
  input  logic [N_CORE-1:0]                req_valid,
  output logic [N_CORE-1:0]                grant,
  output logic [N_CORE-1:0][GC_WIDTH-1:0]  gc_assign,
  output logic                             gd_sign,
  input  logic [N_CORE-1:0]                ending,
  output logic [CNT_WIDTH-1:0]             remaining,
  output logic                             running,
  output logic                             done
);

  localparam int PCW = $clog2(N_CORE) + 1;
  // Core 0 is the parent; forcing its bit high makes the reduction cover
  // only the children and leaves it vacuously true for a single core.
  localparam logic [N_CORE-1:0] PARENT_MASK = N_CORE'(1);

  disp_state_e          state_q, state_d;
  logic [GC_WIDTH-1:0]  gc_q, gc_d;
  logic [GD_WIDTH-1:0]  gd_q, gd_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 done_q, done_d;

  logic [N_CORE-1:0][PCW-1:0] req_prefix;
  logic [N_CORE-1:0][PCW-1:0] grant_prefix;
  logic [PCW-1:0]             req_total;
  logic [PCW-1:0]             grant_total;

  logic                 in_run;
  logic                 all_fit;
  logic                 ending_all;
  logic [GC_WIDTH-1:0]  gd_ext;
  logic [GC_WIDTH-1:0]  gc_step;
  logic [CNT_WIDTH-1:0] rem_after;

  // p_i: requests at lower indices than core i.
  gc_prefix_count #(
    .N  (N_CORE),
    .CW (PCW)
  ) u_req_prefix (
    .bits   (req_valid),
    .prefix (req_prefix),
    .total  (req_total)
  );

  // k_i: grants at lower indices than core i; total is G for the update.
  gc_prefix_count #(
    .N  (N_CORE),
    .CW (PCW)
  ) u_grant_prefix (
    .bits   (grant),
    .prefix (grant_prefix),
    .total  (grant_total)
  );

  assign in_run     = (state_q == DISP_RUN);
  // When every request fits in what is left, no per-core compare matters.
  assign all_fit    = (CNT_WIDTH'(req_total) <= rem_q);
  assign ending_all = &(ending | PARENT_MASK);
  assign gd_ext     = GC_WIDTH'($signed(gd_q));
  assign gc_step    = GC_WIDTH'(grant_total) * gd_ext;
  assign rem_after  = rem_q - CNT_WIDTH'(grant_total);

  genvar gi;
  generate
    for (gi = 0; gi < N_CORE; gi++) begin : g_core
      assign grant[gi] = in_run && req_valid[gi] &&
                         (all_fit || (CNT_WIDTH'(req_prefix[gi]) < rem_q));
      // Modulo-2^GC_WIDTH; a negative stride counts down through zero.
      assign gc_assign[gi] = gc_q + GC_WIDTH'(grant_prefix[gi]) * gd_ext;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    gc_d    = gc_q;
    gd_d    = gd_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      DISP_IDLE: begin
        if (fork_valid) begin
          gc_d    = fork_gc;
          gd_d    = fork_gd;
          rem_d   = fork_count;
          state_d = (fork_count == '0) ? DISP_DRAIN : DISP_RUN;
        end
      end
      DISP_RUN: begin
        // With no grants this leaves gc and remaining untouched.
        gc_d  = gc_q + gc_step;
        rem_d = rem_after;
        if (rem_after == '0) begin
          state_d = DISP_DRAIN;
        end
      end
      DISP_DRAIN: begin
        if (ending_all) begin
          state_d = DISP_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = DISP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DISP_IDLE;
      gc_q    <= '0;
      gd_q    <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gc_q    <= gc_d;
      gd_q    <= gd_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign fork_ready = (state_q == DISP_IDLE);
  assign running    = in_run;
  assign done       = done_q;
  assign remaining  = rem_q;
  assign gd_sign    = gd_q[GD_WIDTH-1];

endmodule : gc_dispatcher

// File: tb/tb_gc_dispatcher.sv
// Scoreboard bench for gc_dispatcher: the stimulus process computes the
// expected outputs for each cycle from a behavioural model and queues them;
// a monitor on the falling edge pops and compares.
module tb_gc_dispatcher;

  localparam int N = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fork_valid = 1'b0;
  logic               fork_ready;
  logic [31:0]        fork_gc = '0;
  logic [15:0]        fork_gd = '0;
  logic [31:0]        fork_count = '0;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       grant;
  logic [N-1:0][31:0] gc_assign;
  logic               gd_sign;
  logic [N-1:0]       ending = '0;
  logic [31:0]        remaining;
  logic               running;
  logic               done;

  always #5 clk = ~clk;

  gc_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .fork_valid (fork_valid),
    .fork_ready (fork_ready),
    .fork_gc    (fork_gc),
    .fork_gd    (fork_gd),
    .fork_count (fork_count),
    .req_valid  (req_valid),
    .grant      (grant),
    .gc_assign  (gc_assign),
    .gd_sign    (gd_sign),
    .ending     (ending),
    .remaining  (remaining),
    .running    (running),
    .done       (done)
  );

  typedef struct {
    logic [N-1:0]       grant;
    logic [N-1:0][31:0] vals;
    logic               running;
    logic               fork_ready;
    logic               gd_sign;
    logic               done;
    logic [31:0]        remaining;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  // Behavioural model: 0 = idle, 1 = handing out indices, 2 = waiting for children.
  int          m_phase;
  logic [31:0] m_gc;
  logic [15:0] m_gd;
  logic [31:0] m_rem;
  logic        m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_gc    = '0;
    m_gd    = '0;
    m_rem   = '0;
    m_done  = 1'b0;
  endtask

  // One clock cycle of stimulus; queues the outputs expected during it.
  task automatic step(input logic r, input logic fv, input logic [31:0] fgc,
                      input logic [15:0] fgd, input logic [31:0] fcnt,
                      input logic [N-1:0] req, input logic [N-1:0] end_v);
    exp_t        e;
    logic [31:0] sgd;
    longint      left;
    int          k;
    @(posedge clk);
    #1;
    rst        = r;
    fork_valid = fv;
    fork_gc    = fgc;
    fork_gd    = fgd;
    fork_count = fcnt;
    req_valid  = req;
    ending     = end_v;

    sgd          = {{16{m_gd[15]}}, m_gd};
    e.grant      = '0;
    e.vals       = '0;
    e.running    = (m_phase == 1);
    e.fork_ready = (m_phase == 0);
    e.gd_sign    = m_gd[15];
    e.done       = m_done;
    e.remaining  = m_rem;
    k            = 0;
    if (m_phase == 1) begin
      // The first min(remaining, #requests) requesters, lowest index first.
      left = longint'(m_rem);
      for (int i = 0; i < N; i++) begin
        if (req[i] && longint'(k) < left) begin
          e.grant[i] = 1'b1;
          e.vals[i]  = m_gc + 32'(k) * sgd;
          k++;
        end
      end
    end
    sb_q.push_back(e);

    m_done = 1'b0;
    if (r) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (fv) begin
        m_gc    = fgc;
        m_gd    = fgd;
        m_rem   = fcnt;
        m_phase = (fcnt == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      m_gc  = m_gc + 32'(k) * sgd;
      m_rem = m_rem - 32'(k);
      if (m_rem == 0) m_phase = 2;
    end else begin
      if (end_v[N-1:1] == '1) begin
        m_phase = 0;
        m_done  = 1'b1;
      end
    end
  endtask

  task automatic cyc_idle(input logic [N-1:0] req, input logic [N-1:0] end_v);
    step(1'b0, 1'b0, 32'd0, 16'd0, 32'd0, req, end_v);
  endtask

  task automatic do_fork(input logic [31:0] fgc, input logic [15:0] fgd, input logic [31:0] fcnt);
    step(1'b0, 1'b1, fgc, fgd, fcnt, '0, '0);
  endtask

  // Monitor: compares each queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cyc++;
        $display("txn %0d: grant=%b rem=%0d run=%0b rdy=%0b done=%0b",
                 cyc, grant, remaining, running, fork_ready, done);
        chk("grant", 32'(grant), 32'(e.grant));
        chk("running", 32'(running), 32'(e.running));
        chk("fork_ready", 32'(fork_ready), 32'(e.fork_ready));
        chk("gd_sign", 32'(gd_sign), 32'(e.gd_sign));
        chk("done", 32'(done), 32'(e.done));
        chk("remaining", remaining, e.remaining);
        for (int i = 0; i < N; i++) begin
          if (e.grant[i]) chk($sformatf("gc_assign[%0d]", i), gc_assign[i], e.vals[i]);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] ev;
    int           wait_cnt;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state, then reset in the middle of RUN.
    cyc_idle('0, '0);
    do_fork(32'd0, 16'd1, 32'd100);
    repeat (3) cyc_idle(6'b111111, '0);
    step(1'b1, 1'b0, 32'd0, 16'd0, 32'd0, 6'b111111, '0);
    cyc_idle(6'b111111, '0);
    cyc_idle('0, '0);

    // Basic stride: cores 0,2,3,5 get 10,13,16,19; then gc=22, remaining=16.
    do_fork(32'd10, 16'd3, 32'd20);
    cyc_idle(6'b101101, '0);
    cyc_idle(6'b000001, '0);
    step(1'b1, 1'b0, 32'd0, 16'd0, 32'd0, '0, '0);

    // Exhaustion tie-break with remaining=2.
    do_fork(32'd50, 16'd7, 32'd2);
    cyc_idle(6'b111111, '0);
    cyc_idle(6'b111111, '0);
    cyc_idle('0, 6'b111110);
    cyc_idle('0, '0);

    // Negative stride wrapping through zero.
    do_fork(32'd1, 16'hFFFF, 32'd3);
    cyc_idle(6'b111111, '0);
    cyc_idle('0, 6'b111110);
    cyc_idle('0, '0);

    // Zero count goes straight to DRAIN; done follows the ending sample.
    do_fork(32'd5, 16'd2, 32'd0);
    repeat (4) cyc_idle('0, 6'b011110);
    cyc_idle('0, 6'b111110);
    cyc_idle('0, '0);
    cyc_idle('0, '0);

    // Fork held while busy: ignored until the first IDLE cycle after done.
    step(1'b0, 1'b1, 32'd100, 16'd2, 32'd4, '0, '0);
    step(1'b0, 1'b1, 32'd999, 16'd5, 32'd3, 6'b000011, '0);
    step(1'b0, 1'b1, 32'd999, 16'd5, 32'd3, 6'b000000, '0);
    step(1'b0, 1'b1, 32'd999, 16'd5, 32'd3, 6'b110000, '0);
    step(1'b0, 1'b1, 32'd999, 16'd5, 32'd3, 6'b000000, 6'b111110);
    step(1'b0, 1'b1, 32'd999, 16'd5, 32'd3, 6'b000000, '0);
    cyc_idle(6'b111111, '0);
    cyc_idle('0, 6'b111110);
    cyc_idle('0, '0);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      rq = N'($urandom);
      ev = ($urandom_range(0, 3) == 0) ? 6'b111110 : N'($urandom);
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) == 0),
           $urandom, 16'($urandom), 32'($urandom_range(0, 12)), rq, ev);
    end
    cyc_idle('0, '0);

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_gc_dispatcher
